// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: state encoding, parity helper and
// default frame geometry used by both the receiver and the matching transmitter.
package serial_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
  localparam int MAX_DATA_BITS    = 9;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef struct packed {
    logic par_err;
    logic frame_err;
    logic valid;
  } rx_strobe_t;

  // Returns the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-stage falling-edge synchronizer for the serial line; both flops preset
// to the idle level (1) while clr is low so reset never looks like a start bit.
module rx_sync (
  input  logic clk,
  input  logic clr,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Oversampling serial frame receiver (start, DATA_BITS LSB first, optional even
// parity when PARITY_EN is defined, one stop); falling-edge state, active-low ce.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 ce,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 par_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  rx_strobe_t           strb_q, strb_d;
  logic                 bit_tick;

  rx_sync u_sync (
    .clk (clk),
    .clr (clr),
    .d_i (rxd),
    .q_o (rx_s)
  );

`ifdef PARITY_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;

  logic                     perr_q, perr_d;
  logic [MAX_DATA_BITS-1:0] par_vec;
  logic                     par_mismatch;

  always_comb begin
    par_vec                = '0;
    par_vec[DATA_BITS-1:0] = shift_q;
  end

  assign par_mismatch = even_parity(par_vec) ^ rx_s;

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  // Full bit cells are timed from the previous sample, so one shared test suffices.
  assign bit_tick = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    strb_d  = '0;
`ifdef PARITY_EN
    perr_d  = perr_q;
`endif
    if (!ce) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
`ifdef PARITY_EN
            perr_d  = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          cnt_d = bit_tick ? '0 : cnt_q + CNT_ONE;
          if (bit_tick) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = ST_AFTER_DATA;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end
        end
`ifdef PARITY_EN
        ST_PARITY: begin
          cnt_d = bit_tick ? '0 : cnt_q + CNT_ONE;
          if (bit_tick) begin
            perr_d  = par_mismatch;
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          cnt_d = bit_tick ? '0 : cnt_q + CNT_ONE;
          if (bit_tick) begin
            data_d = shift_q;
            if (rx_s) begin
              state_d = ST_IDLE;
`ifdef PARITY_EN
              strb_d.valid   = ~perr_q;
              strb_d.par_err = perr_q;
`else
              strb_d.valid   = 1'b1;
`endif
            end else begin
              strb_d.frame_err = 1'b1;
              state_d          = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Hold off until the line returns high so a long low is not a new start.
          if (rx_s) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  assign data      = data_q;
  assign valid     = strb_q.valid;
  assign frame_err = strb_q.frame_err;
  assign par_err   = strb_q.par_err;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: directed frames push expected strobes,
// a posedge monitor pops and checks kind, data and the falling-edge index.
module tb_serial_frame_rx;

  localparam int C  = 4;
  localparam int DB = 8;
`ifdef PARITY_EN
  localparam int PAR_CELLS = 1;
`else
  localparam int PAR_CELLS = 0;
`endif
  // Falling edges from the first edge that samples the start bit to the strobe.
  localparam int LAT = 2 + C / 2 + (DB + 1) * C + PAR_CELLS * C;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          ce  = 1'b0;
  logic          rxd = 1'b1;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          par_err;
  logic          busy;

  serial_frame_rx #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (DB)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .ce        (ce),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .par_err   (par_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(negedge clk) edge_cnt = edge_cnt + 1;

  typedef struct {
    logic [2:0]    kind;   // {par_err, frame_err, valid}
    logic [DB-1:0] dat;
    int            at;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (valid || frame_err || par_err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got kind %b data %0h at edge %0d, expected none",
                 {par_err, frame_err, valid}, data, edge_cnt);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", {29'd0, par_err, frame_err, valid}, {29'd0, e.kind});
        chk("strobe_data", {24'd0, data}, {24'd0, e.dat});
        chk("strobe_edge", edge_cnt, e.at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame; st_cell (cell 0 = start bit) is stretched by st_n clocks
  // while ce is held high for those same clocks.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par_bit,
                            input int st_cell, input int st_n, input logic [2:0] kind);
    logic [DB+2:0] cells;
    int            ncell;
    exp_t          e;
    cells    = '0;
    cells[0] = 1'b0;
    for (int i = 0; i < DB; i++) cells[1+i] = d[i];
    ncell = DB + 1;
`ifdef PARITY_EN
    cells[ncell] = par_bit;
    ncell++;
`endif
    cells[ncell] = stop_bit;
    ncell++;
    e.kind = kind;
    e.dat  = d;
    e.at   = edge_cnt + 1 + LAT + st_n;
    sb.push_back(e);
    for (int k = 0; k < ncell; k++) begin
      rxd = cells[k];
      if (k == st_cell) begin
        tick(1);
        ce = 1'b1;
        tick(st_n);
        ce = 1'b0;
        tick(C - 1);
      end else begin
        tick(C);
      end
    end
  endtask

  initial begin
    logic [3:0] busy_pat;
    exp_t       e;

    tick(1);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_par_err", {31'd0, par_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    clr = 1'b1;
    tick(3);

    // Plain good frame
    send_frame(8'hA5, 1'b1, ^8'hA5, -1, 0, 3'b001);
    tick(3);
    chk("a5_busy_idle", {31'd0, busy}, 32'd0);
    chk("a5_data_hold", {24'd0, data}, 32'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h12, 1'b1, ^8'h12, -1, 0, 3'b001);
    send_frame(8'hED, 1'b1, ^8'hED, -1, 0, 3'b001);
    tick(3);
    chk("b2b_data", {24'd0, data}, 32'hED);

    // One-clock glitch: busy for two enabled edges, no strobe
    tick(2);
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    busy_pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("glitch_busy", {31'd0, busy}, {31'd0, busy_pat[3-i]});
    end
    tick(3);

    // Stop bit low, line held low: frame_err then BREAK until line high
    send_frame(8'h3C, 1'b0, ^8'h3C, -1, 0, 3'b010);
    tick(20);
    chk("break_busy_low_line", {31'd0, busy}, 32'd1);
    chk("ferr_data", {24'd0, data}, 32'h3C);
    rxd = 1'b1;
    tick(1);
    chk("break_busy_rx_s_lag", {31'd0, busy}, 32'd1);
    tick(2);
    chk("break_exit_busy", {31'd0, busy}, 32'd0);
    tick(2);

    // Reset mid-frame during bit 4 of 0xFF
    rxd = 1'b0;
    tick(C);
    rxd = 1'b1;
    tick(4 * C + 2);
    chk("pre_clr_busy", {31'd0, busy}, 32'd1);
    clr = 1'b0;
    #1;
    chk("clr_data", {24'd0, data}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_valid", {31'd0, valid}, 32'd0);
    chk("clr_frame_err", {31'd0, frame_err}, 32'd0);
    tick(2);
    clr = 1'b1;
    tick(4);
    send_frame(8'h81, 1'b1, ^8'h81, -1, 0, 3'b001);
    tick(3);
    chk("post_clr_data", {24'd0, data}, 32'h81);

    // ce high for 10 clocks during data bit 3, sender stretched to match
    send_frame(8'h5A, 1'b1, ^8'h5A, 4, 10, 3'b001);
    tick(3);
    chk("ce_data", {24'd0, data}, 32'h5A);

    // Strobe must still drop on the next edge with ce high
    send_frame(8'hC3, 1'b1, ^8'hC3, -1, 0, 3'b001);
    tick(1);
    chk("ce_strobe_up", {31'd0, valid}, 32'd1);
    ce = 1'b1;
    tick(1);
    chk("ce_strobe_down", {31'd0, valid}, 32'd0);
    tick(2);
    ce = 1'b0;
    tick(2);

`ifdef PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1, 0, 3'b100);
    tick(3);
    send_frame(8'h07, 1'b1, 1'b1, -1, 0, 3'b001);
    tick(3);
    chk("par_data", {24'd0, data}, 32'h07);
`endif

    for (int i = 0; i < 500 && sb.size() > 0; i++) tick(1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL strobe_timeout: got no strobe, expected kind %b data %0h at edge %0d",
               e.kind, e.dat, e.at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
